// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router widths, depths and the buffered word layout
package router_pkg;

  localparam int DATA_W           = 8;
  localparam int FIFO_DEPTH       = 16;
  localparam int SOFT_RST_TIMEOUT = 30;

  typedef struct packed {
    logic              hdr;
    logic [DATA_W-1:0] data;
  } fifo_word_t;

endpackage

// File: rtl/router_dst_watchdog.sv
// rtl/router_dst_watchdog.sv - read-timeout counter; flush fires on the edge soft_reset rises
module router_dst_watchdog
  import router_pkg::*;
#(
  parameter int TIMEOUT = SOFT_RST_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic valid_out,
  input  logic read_enb,
  output logic flush,
  output logic soft_reset
);

  localparam int            CW     = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_C = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          soft_q, soft_d;
  logic          counting;

  assign counting   = valid_out && !read_enb;
  // flush is combinational so the buffer empties on the same edge soft_reset rises
  assign flush      = counting && (cnt_q == LAST_C);
  assign soft_reset = soft_q;

  always_comb begin
    cnt_d  = '0;
    soft_d = flush;
    if (counting && !flush) begin
      cnt_d = cnt_q + ONE_C;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      soft_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      soft_q <= soft_d;
    end
  end

endmodule

// File: rtl/router_dst_fifo.sv
// rtl/router_dst_fifo.sv - per-output-port byte buffer with header tag and read-timeout flush
module router_dst_fifo
  import router_pkg::*;
#(
  parameter int DEPTH   = FIFO_DEPTH,
  parameter int TIMEOUT = SOFT_RST_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_enb,
  input  logic [DATA_W-1:0] data_in,
  input  logic              lfd_state,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              hdr_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              soft_reset
);

  localparam int            AW      = $clog2(DEPTH);
  localparam int            PW      = AW + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_C   = PW'(1);
  localparam logic [AW-1:0] ONE_A   = AW'(1);

  fifo_word_t        mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              hdr_q, hdr_d;
  logic              wr_fire, rd_fire, flush;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign valid_out = !empty;
  assign data_out  = data_q;
  assign hdr_out   = hdr_q;

  // a flush swallows any write or read presented in the same cycle
  assign wr_fire = write_enb && !full && !flush;
  assign rd_fire = read_enb && !empty && !flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    data_d  = data_q;
    hdr_d   = hdr_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      data_d  = '0;
      hdr_d   = 1'b0;
    end else begin
      if (wr_fire) begin
        wptr_d = {1'b0, wptr_q[AW-1:0] + ONE_A};
      end
      if (rd_fire) begin
        rptr_d = {1'b0, rptr_q[AW-1:0] + ONE_A};
        data_d = mem_q[rptr_q[AW-1:0]].data;
        hdr_d  = mem_q[rptr_q[AW-1:0]].hdr;
      end
      case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      hdr_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      data_q  <= data_d;
      hdr_q   <= hdr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem_q[wptr_q[AW-1:0]] <= '{hdr: lfd_state, data: data_in};
    end
  end

  router_dst_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .valid_out (valid_out),
    .read_enb  (read_enb),
    .flush     (flush),
    .soft_reset(soft_reset)
  );

endmodule

// File: tb/tb_router_dst_fifo.sv
// tb/tb_router_dst_fifo.sv - directed self-checking bench for router_dst_fifo
module tb_router_dst_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic       write_enb;
  logic [7:0] data_in;
  logic       lfd_state;
  logic       read_enb;
  logic [7:0] data_out;
  logic       hdr_out;
  logic       valid_out;
  logic       full;
  logic       empty;
  logic       soft_reset;

  int checks = 0;
  int errors = 0;

  router_dst_fifo dut (
    .clock     (clock),
    .reset     (reset),
    .write_enb (write_enb),
    .data_in   (data_in),
    .lfd_state (lfd_state),
    .read_enb  (read_enb),
    .data_out  (data_out),
    .hdr_out   (hdr_out),
    .valid_out (valid_out),
    .full      (full),
    .empty     (empty),
    .soft_reset(soft_reset)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d, input logic h);
    write_enb = 1'b1;
    data_in   = d;
    lfd_state = h;
    tick();
    write_enb = 1'b0;
    lfd_state = 1'b0;
  endtask

  task automatic rd(input logic [7:0] d, input logic h, input string tag);
    read_enb = 1'b1;
    tick();
    read_enb = 1'b0;
    chk(tag, {23'd0, h, d}, {23'd0, hdr_out, data_out});
  endtask

  logic [7:0] pkt [5];

  initial begin
    reset = 1'b1; write_enb = 1'b0; data_in = '0; lfd_state = 1'b0; read_enb = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_empty", empty, 1'b1);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_data", {hdr_out, data_out}, 9'h000);
    chk("rst_soft", soft_reset, 1'b0);

    // packet pass-through with read_enb held high
    pkt[0] = 8'h0C; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h0C;
    wr(pkt[0], 1'b1);
    chk("wr_valid_lat", valid_out, 1'b1);
    for (int i = 1; i < 5; i++) wr(pkt[i], 1'b0);
    read_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("pkt_data", {hdr_out, data_out}, {(i == 0), pkt[i]});
      chk("pkt_valid", valid_out, (i < 4));
    end
    read_enb = 1'b0;

    // full, dropped write, wrap-around
    for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
    chk("full_set", full, 1'b1);
    wr(8'hFF, 1'b0);
    chk("full_drop", full, 1'b1);
    for (int i = 0; i < 4; i++) rd(8'(i), 1'b0, "wrap_rd_a");
    chk("full_clr", full, 1'b0);
    for (int i = 0; i < 4; i++) wr(8'hA0 + 8'(i), 1'b0);
    chk("full_again", full, 1'b1);
    for (int i = 4; i < 16; i++) rd(8'(i), 1'b0, "wrap_rd_b");
    for (int i = 0; i < 4; i++) rd(8'hA0 + 8'(i), 1'b0, "wrap_rd_c");
    chk("wrap_empty", empty, 1'b1);

    // read while empty: output holds, pointers do not move
    rd(8'hA3, 1'b0, "empty_rd_hold");
    wr(8'h5A, 1'b0);
    rd(8'h5A, 1'b0, "empty_rd_ptr");
    chk("empty_rd_empty", empty, 1'b1);

    // simultaneous read and write at count 5
    for (int i = 0; i < 5; i++) wr(8'h30 + 8'(i), 1'b0);
    write_enb = 1'b1; read_enb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 8'h35 + 8'(i);
      tick();
      chk("simul_data", data_out, 8'h30 + 8'(i));
    end
    write_enb = 1'b0; read_enb = 1'b0;
    for (int i = 0; i < 4; i++) rd(8'h33 + 8'(i), 1'b0, "simul_drain");
    chk("simul_cnt_valid", valid_out, 1'b1);
    rd(8'h37, 1'b0, "simul_drain_last");
    chk("simul_cnt_empty", empty, 1'b1);

    // timeout: 30 qualifying edges counted from the edge after the first write
    wr(8'h41, 1'b1); wr(8'h42, 1'b0); wr(8'h43, 1'b0);
    for (int i = 0; i < 27; i++) tick();
    chk("to_pre_soft", soft_reset, 1'b0);
    chk("to_pre_valid", valid_out, 1'b1);
    tick();
    chk("to_soft", soft_reset, 1'b1);
    chk("to_empty", empty, 1'b1);
    chk("to_data", {hdr_out, data_out}, 9'h000);
    tick();
    chk("to_soft_pulse", soft_reset, 1'b0);

    // a single read at the last edge prevents the timeout and restarts the count
    wr(8'h51, 1'b0); wr(8'h52, 1'b0); wr(8'h53, 1'b0);
    for (int i = 0; i < 27; i++) tick();
    rd(8'h51, 1'b0, "to2_read");
    chk("to2_no_soft", soft_reset, 1'b0);
    for (int i = 0; i < 29; i++) tick();
    chk("to2_pre_soft", soft_reset, 1'b0);
    chk("to2_pre_valid", valid_out, 1'b1);
    tick();
    chk("to2_soft", soft_reset, 1'b1);
    chk("to2_empty", empty, 1'b1);
    chk("to2_data", data_out, 8'h00);

    // reset mid-operation
    wr(8'h77, 1'b1);
    rd(8'h77, 1'b1, "mid_rd");
    wr(8'h78, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_data", {hdr_out, data_out}, 9'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
